// File: rtl/mem_arbiter.sv
// Shared main-memory arbiter between the I-cache and D-cache miss handlers.
// D-side requests win; fills are BLK_WORDS back-to-back reads, writes are single-word.
module mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int BLK_WORDS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ic_req,
    input  logic [ADDR_W-1:0]            ic_addr,
    output logic                         ic_grant,
    output logic                         ic_data_vld,
    output logic                         ic_done,
    input  logic                         dc_req,
    input  logic                         dc_we,
    input  logic [ADDR_W-1:0]            dc_addr,
    input  logic [DATA_W-1:0]            dc_wdata,
    output logic                         dc_grant,
    output logic                         dc_data_vld,
    output logic                         dc_done,
    output logic [DATA_W-1:0]            rd_data,
    output logic [$clog2(BLK_WORDS)-1:0] rd_idx,
    output logic                         mem_en,
    output logic                         mem_wr,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    input  logic                         mem_rvalid
);

    localparam int IDX_W = $clog2(BLK_WORDS);
    localparam logic [ADDR_W-1:0] BLK_MASK  = ~ADDR_W'(BLK_WORDS * 2 - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BLK_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_owner_d;
    logic                r_ic_grant;
    logic                r_dc_grant;
    logic                r_mem_en;
    logic                r_mem_wr;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [IDX_W-1:0]    r_issue_cnt;
    logic [IDX_W-1:0]    r_ret_cnt;

    logic                w_busy;
    logic                w_ret;
    logic                w_last_ret;
    logic                w_last_issue;
    logic [ADDR_W-1:0]   w_ic_base;
    logic [ADDR_W-1:0]   w_dc_base;

    assign w_busy       = (r_state == S_FILL) || (r_state == S_DRAIN);
    assign w_ret        = w_busy && mem_rvalid;
    assign w_last_ret   = w_ret && (r_ret_cnt == LAST_IDX);
    assign w_last_issue = (r_issue_cnt == LAST_IDX);
    assign w_ic_base    = ic_addr & BLK_MASK;
    assign w_dc_base    = dc_addr & BLK_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_owner_d   <= 1'b0;
            r_ic_grant  <= 1'b0;
            r_dc_grant  <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
        end else begin
            // Returns are only meaningful while a fill owns the memory.
            if (w_ret) begin
                r_ret_cnt <= r_ret_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (dc_req && dc_we) begin
                        r_state     <= S_WRITE;
                        r_owner_d   <= 1'b1;
                        r_dc_grant  <= 1'b1;
                        r_mem_en    <= 1'b1;
                        r_mem_wr    <= 1'b1;
                        r_mem_addr  <= dc_addr & WORD_MASK;
                        r_mem_wdata <= dc_wdata;
                    end else if (dc_req || ic_req) begin
                        r_state     <= S_FILL;
                        r_owner_d   <= dc_req;
                        r_dc_grant  <= dc_req;
                        r_ic_grant  <= !dc_req;
                        r_mem_en    <= 1'b1;
                        r_mem_wr    <= 1'b0;
                        r_mem_addr  <= dc_req ? w_dc_base : w_ic_base;
                        r_issue_cnt <= '0;
                        r_ret_cnt   <= '0;
                    end
                end

                S_FILL: begin
                    r_issue_cnt <= r_issue_cnt + 1'b1;
                    if (w_last_issue) begin
                        r_state    <= S_DRAIN;
                        r_mem_en   <= 1'b0;
                        r_mem_addr <= '0;
                    end else begin
                        r_mem_addr <= r_mem_addr + ADDR_W'(2);
                    end
                    // Only reachable with a zero-latency memory: last word back on last issue.
                    if (w_last_ret) begin
                        r_state    <= S_IDLE;
                        r_ic_grant <= 1'b0;
                        r_dc_grant <= 1'b0;
                    end
                end

                S_DRAIN: begin
                    if (w_last_ret) begin
                        r_state    <= S_IDLE;
                        r_ic_grant <= 1'b0;
                        r_dc_grant <= 1'b0;
                    end
                end

                S_WRITE: begin
                    r_state     <= S_IDLE;
                    r_dc_grant  <= 1'b0;
                    r_mem_en    <= 1'b0;
                    r_mem_wr    <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ic_grant    = r_ic_grant;
    assign dc_grant    = r_dc_grant;
    assign ic_data_vld = w_ret && !r_owner_d;
    assign dc_data_vld = w_ret && r_owner_d;
    assign ic_done     = w_last_ret && !r_owner_d;
    assign dc_done     = (w_last_ret && r_owner_d) || (r_state == S_WRITE);
    assign rd_data     = mem_rdata;
    assign rd_idx      = r_ret_cnt;
    assign mem_en      = r_mem_en;
    assign mem_wr      = r_mem_wr;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction table plus reset, priority and preemption sequences.
// The memory model returns each read exactly four cycles after it is issued.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ic_req, dc_req, dc_we;
    logic [15:0] ic_addr, dc_addr, dc_wdata;
    logic        ic_grant, ic_data_vld, ic_done;
    logic        dc_grant, dc_data_vld, dc_done;
    logic [15:0] rd_data;
    logic [2:0]  rd_idx;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rvalid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .BLK_WORDS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_grant(ic_grant),
        .ic_data_vld(ic_data_vld), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_grant(dc_grant), .dc_data_vld(dc_data_vld), .dc_done(dc_done),
        .rd_data(rd_data), .rd_idx(rd_idx),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    function automatic logic [15:0] md(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    // Fixed-latency read pipeline; deliberately not reset by rst_n.
    logic [3:0]  pv = 4'b0;
    logic [15:0] pa [4];
    always @(posedge clk) begin
        pv    <= {pv[2:0], mem_en & ~mem_wr};
        pa[0] <= mem_addr;
        pa[1] <= pa[0];
        pa[2] <= pa[1];
        pa[3] <= pa[2];
    end
    assign mem_rvalid = pv[3];
    assign mem_rdata  = pv[3] ? md(pa[3]) : 16'h0;

    logic [63:0] w_outs;
    assign w_outs = {21'b0, ic_grant, ic_data_vld, ic_done, dc_grant, dc_data_vld, dc_done,
                     mem_en, mem_wr, rd_idx, mem_addr, mem_wdata};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Follows one transaction from the cycle after its request is sampled through the idle gap.
    task automatic watch(input logic is_dc, input logic we, input logic [15:0] base,
                         input logic [15:0] wdata, input int exp_gc, input string nm);
        int issued = 0, rets = 0, gc = 0, first = 0, cyc = 0, wrong = 0, both = 0;
        logic done = 1'b0;
        logic g, v, d, ov, od;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            g  = is_dc ? dc_grant    : ic_grant;
            v  = is_dc ? dc_data_vld : ic_data_vld;
            d  = is_dc ? dc_done     : ic_done;
            ov = is_dc ? ic_data_vld : dc_data_vld;
            od = is_dc ? ic_done     : dc_done;
            if (ic_grant && dc_grant) both++;
            if (ov || od) wrong++;
            if (g) begin
                gc++;
                if (first == 0) first = cyc;
            end
            if (mem_en) begin
                chk({nm, "_addr"}, 64'(mem_addr), 64'(base + 16'(2 * issued)));
                chk({nm, "_wr"}, 64'(mem_wr), 64'(we));
                if (we) chk({nm, "_wdata"}, 64'(mem_wdata), 64'(wdata));
                issued++;
            end
            if (v) begin
                chk({nm, "_idx"}, 64'(rd_idx), 64'(rets % 8));
                chk({nm, "_data"}, 64'(rd_data), 64'(md(base + 16'(2 * rets))));
                rets++;
            end
            if (d) done = 1'b1;
        end
        chk({nm, "_done_seen"}, 64'(done), 64'd1);
        chk({nm, "_grant_cycles"}, 64'(gc), 64'(exp_gc));
        chk({nm, "_grant_latency"}, 64'(first), 64'd1);
        chk({nm, "_issues"}, 64'(issued), we ? 64'd1 : 64'd8);
        chk({nm, "_returns"}, 64'(rets), we ? 64'd0 : 64'd8);
        chk({nm, "_other_side_quiet"}, 64'(wrong), 64'd0);
        chk({nm, "_grant_exclusive"}, 64'(both), 64'd0);
        if (is_dc) dc_req = 1'b0;
        else       ic_req = 1'b0;
        $display("txn %s: owner=%s we=%0d base=0x%04h grant_cycles=%0d issues=%0d returns=%0d",
                 nm, is_dc ? "D" : "I", we, base, gc, issued, rets);
        @(negedge clk);
        chk({nm, "_idle_gap"}, 64'({ic_grant, dc_grant, mem_en}), 64'd0);
    endtask

    typedef struct {
        logic        is_dc;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_base;
        int          exp_gc;
        string       nm;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int n, cyc, late, bad;

        vecs[0] = '{1'b1, 1'b1, 16'h0011, 16'hBEEF, 16'h0010, 1,  "dwrite_0011"};
        vecs[1] = '{1'b0, 1'b0, 16'h00FF, 16'h0000, 16'h00F0, 12, "ifill_00ff"};
        vecs[2] = '{1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'hFFF0, 12, "dfill_fffe"};
        vecs[3] = '{1'b1, 1'b1, 16'h8001, 16'h1234, 16'h8000, 1,  "dwrite_8001"};
        vecs[4] = '{1'b0, 1'b0, 16'h7FF1, 16'h0000, 16'h7FF0, 12, "ifill_7ff1"};
        vecs[5] = '{1'b1, 1'b0, 16'h0008, 16'h0000, 16'h0000, 12, "dfill_0008"};

        rst_n    = 1'b0;
        ic_req   = 1'b1;
        dc_req   = 1'b1;
        dc_we    = 1'b0;
        ic_addr  = 16'h1236;
        dc_addr  = 16'h4000;
        dc_wdata = 16'h0;

        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", w_outs, 64'd0);
            chk("reset_rd_data_pass", 64'(rd_data), 64'(mem_rdata));
        end
        rst_n = 1'b1;

        // Both requests pending at release: D fill first, then I after one idle cycle.
        watch(1'b1, 1'b0, 16'h4000, 16'h0, 12, "sim_dfill_4000");
        watch(1'b0, 1'b0, 16'h1230, 16'h0, 12, "sim_ifill_1236");

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].is_dc) begin
                dc_we    = vecs[i].we;
                dc_addr  = vecs[i].addr;
                dc_wdata = vecs[i].wdata;
                dc_req   = 1'b1;
            end else begin
                ic_addr = vecs[i].addr;
                ic_req  = 1'b1;
            end
            watch(vecs[i].is_dc, vecs[i].we, vecs[i].exp_base, vecs[i].wdata,
                  vecs[i].exp_gc, vecs[i].nm);
        end

        // D request raised during the third cycle of an I fill waits for the I fill to finish.
        ic_addr = 16'h0A0C;
        ic_req  = 1'b1;
        fork
            watch(1'b0, 1'b0, 16'h0A00, 16'h0, 12, "ifill_preempted");
            begin
                repeat (3) @(negedge clk);
                dc_we   = 1'b0;
                dc_addr = 16'h2222;
                dc_req  = 1'b1;
            end
        join
        watch(1'b1, 1'b0, 16'h2220, 16'h0, 12, "dfill_after_i");

        // Reset pulse after five accepted issues of an I fill.
        ic_addr = 16'h3000;
        ic_req  = 1'b1;
        n   = 0;
        cyc = 0;
        while (n < 6 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (mem_en) n++;
        end
        chk("rst_reach_issue6", 64'(n), 64'd6);
        #1 rst_n = 1'b0;
        ic_req = 1'b0;
        #1 chk("async_reset_outputs", w_outs, 64'd0);
        #1 rst_n = 1'b1;
        late = 0;
        bad  = 0;
        repeat (8) begin
            @(negedge clk);
            if (mem_rvalid) late++;
            if (ic_data_vld || ic_done || ic_grant || dc_grant || dc_data_vld || dc_done || mem_en) bad++;
        end
        chk("late_rvalid_count", 64'(late), 64'd3);
        chk("late_rvalid_ignored", 64'(bad), 64'd0);
        $display("txn reset_mid_fill: late_returns=%0d reacted=%0d", late, bad);

        ic_addr = 16'h5678;
        ic_req  = 1'b1;
        watch(1'b0, 1'b0, 16'h5670, 16'h0, 12, "ifill_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single shared multi-cycle main memory between the I-cache miss handler and the D-cache miss/write-through handler.
- Read fills are whole 16-byte blocks of 8 words, issued back-to-back and returned in order. D-cache writes are single-word write-through.
- Sits between both cache fill FSMs and the memory model. Fill data and done pulses go to the owning cache; the pipeline stalls on the caches' miss signals.
- Fixed priority, D-cache over I-cache: the D-side miss always belongs to the older instruction.

Parameters:
- ADDR_W, 16, byte address width
- DATA_W, 16, word width
- BLK_WORDS, 8, words per block fill (power of 2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous active-low
- ic_req  in  1  I-cache fill request; held until ic_done
- ic_addr  in  ADDR_W  I-cache miss address
- ic_grant  out  1  I-cache owns memory
- ic_data_vld  out  1  rd_data is a fill word for the I-cache
- ic_done  out  1  one-cycle pulse on the last I-cache fill word
- dc_req  in  1  D-cache request; held until dc_done
- dc_we  in  1  1 = single-word write, 0 = block fill
- dc_addr  in  ADDR_W  D-cache address
- dc_wdata  in  DATA_W  write data
- dc_grant  out  1  D-cache owns memory
- dc_data_vld  out  1  rd_data is a fill word for the D-cache
- dc_done  out  1  one-cycle pulse on the last fill word or on write issue
- rd_data  out  DATA_W  returned word, shared by both caches
- rd_idx  out  log2(BLK_WORDS)  word index within the block for rd_data
- mem_en  out  1  memory access strobe
- mem_wr  out  1  write when mem_en
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_rvalid  in  1  mem_rdata valid; one pulse per read, in issue order

Behaviour:
- States: IDLE, FILL, DRAIN, WRITE.
- Reset (async, rst_n low): state IDLE; counters 0. All outputs are 0: grants, vlds, dones, mem_en, mem_wr, mem_addr, mem_wdata, rd_idx. rd_data = mem_rdata passthrough.
- IDLE:
  - dc_req wins over ic_req.
  - dc_req & dc_we: go to WRITE, latch dc_addr/dc_wdata.
  - dc_req & !dc_we: go to FILL, owner = D.
  - else ic_req: go to FILL, owner = I.
  - Latched base = addr with the low log2(BLK_WORDS*2) bits forced to 0.
  - Grant asserts the cycle after the request is sampled.
- FILL: lasts BLK_WORDS cycles. mem_en = 1, mem_wr = 0, mem_addr = base + 2*issue_cnt, issue_cnt 0..BLK_WORDS-1. After the last issue go to DRAIN.
- Returns, counted in FILL and DRAIN:
  - Each mem_rvalid pulses the owner's *_data_vld combinationally with rd_data = mem_rdata and rd_idx = ret_cnt; ret_cnt then increments.
  - On the BLK_WORDS-th return, the owner's *_done pulses in the same cycle. Next state is IDLE; grant drops next cycle.
- WRITE: one cycle with dc_grant = 1, mem_en = 1, mem_wr = 1, mem_addr = latched address with bit 0 cleared, mem_wdata = latched data, dc_done = 1. Then IDLE.
- The grant stays high from the first issue cycle through the done cycle. ic_grant and dc_grant are never both 1.
- Back-to-back: re-arbitration happens in IDLE, so consecutive transfers have a 1-cycle IDLE gap.
- A request deasserted mid-transfer does not abort it. The transfer completes and done still pulses.
- A request arriving during a transfer waits; a pending dc_req preempts a pending ic_req at the next IDLE.
- mem_rvalid in IDLE or WRITE is ignored: no vld, no counter change.
- Reset mid-transfer aborts immediately. Late mem_rvalid pulses after reset are ignored per the rule above.
- ret_cnt and issue_cnt wrap modulo BLK_WORDS and are cleared on entry to FILL.

Test Plan:
- Reset and idle: hold rst_n = 0 with ic_req = dc_req = 1, then release. All outputs stay 0 during reset; the first grant is dc_grant, one cycle after release.
- I-cache fill, memory latency 4: ic_req with ic_addr = 0x1236.
  - mem_addr = 0x1230, 0x1232, ..., 0x123E on 8 consecutive mem_en cycles.
  - 8 ic_data_vld with rd_idx 0..7, ic_done on the 8th; ic_grant high for 12 cycles.
- Simultaneous ic_req and dc_req (fill, dc_addr = 0x4000) in the same cycle:
  - D fill completes first.
  - One IDLE cycle follows, then ic_grant rises. No overlap, and no ic_data_vld during the D fill.
- D write: dc_req, dc_we = 1, dc_addr = 0x0011, dc_wdata = 0xBEEF. Next cycle shows mem_en = mem_wr = 1, mem_addr = 0x0010, mem_wdata = 0xBEEF and dc_done = 1; IDLE on the following cycle.
- dc_req raised during the 3rd cycle of an I fill: the I fill completes untouched, then dc_grant follows after the 1-cycle gap.
- rst_n pulsed low after 5 issues of a fill:
  - Outputs go to 0 asynchronously.
  - The remaining mem_rvalid pulses produce no vld or done.
  - A fresh ic_req after reset fills correctly from rd_idx 0.
